natv_arb2: RTL and testbench
============================

Name: natv_arb2

Overview:
- Two-master round-robin arbiter on the native (natv) bus. Sits directly upstream of the native peripheral wrapper.
- Master 0 is the CPU data port; master 1 is a second requester (DMA or debug).
- Forwards one transaction at a time to the single natv slave port and routes rdata/ready back to the granted master.
- The optional watchdog unsticks the bus when the slave never answers.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with the optional feature); legal range 2..65535.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  reset: one clock; reset is asynchronous and active-low.
- m0_valid_i  in  1  master 0 request; held high until m0_ready_o.
- m0_addr_i  in  ADDR_W  master 0 address.
- m0_wdata_i  in  DATA_W  master 0 write data.
- m0_wstrb_i  in  DATA_W/8  master 0 byte strobes; 0 means read.
- m0_rdata_o  out  DATA_W  master 0 read data, valid with m0_ready_o.
- m0_ready_o  out  1  master 0 one-cycle completion pulse.
- m1_valid_i, m1_addr_i, m1_wdata_i, m1_wstrb_i, m1_rdata_o, m1_ready_o: same as master 0, for master 1.
- s_valid_o  out  1  request to the natv slave.
- s_addr_o  out  ADDR_W  forwarded address.
- s_wdata_o  out  DATA_W  forwarded write data.
- s_wstrb_o  out  DATA_W/8  forwarded strobes.
- s_rdata_i  in  DATA_W  slave read data.
- s_ready_i  in  1  slave completion pulse.
- timeout_o  out  1  one-cycle pulse when the watchdog fires; tied 0 without the feature.

Behaviour:
- Reset values:
  - FSM = IDLE; grant = none; last-grant pointer = 1, so m0 wins the first tie.
  - All outputs 0.
- FSM states:
  - IDLE: no request forwarded; s_valid_o=0.
  - GRANT: a grant is registered and s_valid_o is driven from the granted master.
  - DONE: one dead cycle after completion.
- IDLE -> GRANT:
  - Taken on the clock edge when any m*_valid_i=1.
  - One request: grant that master.
  - Both request: grant the master not in the last-grant pointer; update the pointer on grant.
- GRANT, forwarding:
  - s_valid_o = granted master's valid.
  - s_addr_o/s_wdata_o/s_wstrb_o = granted master's signals, through a combinational mux on the registered grant.
  - The non-granted master's ready stays 0.
- GRANT, completion:
  - When s_ready_i=1, drive granted m*_ready_o=1 and m*_rdata_o=s_rdata_i in the same cycle (combinational).
  - Go to DONE.
  - m*_rdata_o is 0 whenever its ready is 0.
- DONE:
  - Forces s_valid_o=0 for one cycle. This covers a slave that gates on its own registered ready, and lets the master drop valid.
  - Then go to IDLE.
- Latency:
  - Request to s_valid_o is 1 cycle.
  - s_ready_i to master ready is 0 cycles.
  - Back-to-back transactions from one master: minimum 3 cycles each when the slave answers in 1.
- Boundaries:
  - Granted master drops valid in GRANT before s_ready_i (protocol violation): go to IDLE, no ready issued, pointer unchanged.
  - s_ready_i while in IDLE or DONE: ignored, no master ready.
  - A new request arriving in the same cycle as completion: not granted until after DONE.
  - Asynchronous reset mid-transaction: everything returns to reset values immediately; the slave sees s_valid_o fall with no completion.
- Fairness:
  - With both masters continuously requesting, grants strictly alternate.

Optional Feature:
- Macro: NATV_ARB_TIMEOUT_EN.
- Enabled:
  - A 16-bit counter clears on entering GRANT and increments each GRANT cycle without s_ready_i.
  - When the count reaches TIMEOUT_CYC-1:
    - Granted master gets ready=1 and rdata=32'hDEAD_BEEF.
    - timeout_o pulses for 1 cycle.
    - FSM goes to DONE; s_valid_o drops.
  - If s_ready_i arrives in the same cycle as the timeout, the real completion wins: rdata=s_rdata_i and no timeout_o.
- Disabled: no counter; GRANT waits forever; timeout_o=0.

Decomposition:
- Package natv_arb_pkg holds:
  - FSM state enum {IDLE, GRANT, DONE}.
  - NATV_ERR_RDATA = 32'hDEAD_BEEF.
  - Grant index type (1 bit + valid).
- Sub-module natv_arb_wdog, instantiated only under the macro:
  - Inputs: clear, count-enable.
  - Output: expired pulse.

Test Plan:
- Single read: m0 addr 0x1000, wstrb 0, slave returns 0x1234_5678 after 1 cycle -> s_valid_o rises 1 cycle after m0_valid_i; m0_ready_o pulses once with rdata 0x1234_5678; m1_ready_o stays 0.
- Tie: m0 and m1 both valid from reset -> grant order m0, m1, m0, m1 over 4 transactions; s_addr_o matches the granted master each time.
- Write forwarding: m1 writes 0xA5 to 0x0000 with wstrb 0x1 -> s_wdata_o=0xA5, s_wstrb_o=0x1 while granted; m1_ready_o pulse; a DONE cycle with s_valid_o=0 follows.
- Abort and stray ready: m0 drops valid mid-GRANT -> IDLE, no ready. Stray s_ready_i in IDLE -> no master ready.
- Reset mid-op: rst_n_i low during GRANT -> s_valid_o=0 immediately. After release, a tie grants m0 first.
- Timeout (NATV_ARB_TIMEOUT_EN, TIMEOUT_CYC=8): slave silent -> m0_ready_o with 0xDEAD_BEEF in the 8th GRANT cycle, timeout_o pulses once. Repeat with s_ready_i arriving in that same cycle -> real data returned, no timeout_o.

Source files
------------

// File: rtl/natv_arb_pkg.sv
// natv_arb_pkg: shared types and constants for the two-master natv arbiter.
// Holds the arbiter FSM state enum, the grant index type and the error read data.
package natv_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Registered grant: vld=0 means no master owns the slave port.
    typedef struct packed {
        logic vld;
        logic idx;
    } gnt_t;

    localparam logic [31:0] NATV_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/natv_arb_wdog.sv
// natv_arb_wdog: 16-bit watchdog counter for the natv arbiter (NATV_ARB_TIMEOUT_EN).
// Ports: clk_i, rst_n_i, clr_i (clear), cnt_en_i (count), expired_o (pulse at limit).
module natv_arb_wdog
    import natv_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic cnt_en_i,
    output logic expired_o
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYC - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_en_i) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Fires in the cycle the count sits at the limit while still waiting.
    assign expired_o = cnt_en_i && (cnt_q == LIMIT);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/natv_arb2.sv
// natv_arb2: two-master round-robin arbiter in front of a single natv slave.
// Ports: m0_*/m1_* master request/response, s_* slave port, timeout_o; macro NATV_ARB_TIMEOUT_EN adds watchdog.
module natv_arb2
    import natv_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                m0_valid_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    input  logic [DATA_W/8-1:0] m0_wstrb_i,
    output logic [DATA_W-1:0]   m0_rdata_o,
    output logic                m0_ready_o,
    input  logic                m1_valid_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    input  logic [DATA_W/8-1:0] m1_wstrb_i,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic                m1_ready_o,
    output logic                s_valid_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    output logic [DATA_W/8-1:0] s_wstrb_o,
    input  logic [DATA_W-1:0]   s_rdata_i,
    input  logic                s_ready_i,
    output logic                timeout_o
);

    state_e state_q;
    state_e state_d;
    gnt_t   gnt_q;
    gnt_t   gnt_d;
    logic   last_q;
    logic   last_d;

    logic              in_gnt;
    logic              gnt_valid;
    logic              hit;
    logic              expired;
    logic              fin;
    logic              pick;
    logic [DATA_W-1:0] rsp;

    assign in_gnt    = (state_q == ST_GRANT) && gnt_q.vld;
    assign gnt_valid = gnt_q.idx ? m1_valid_i : m0_valid_i;
    assign hit       = in_gnt && gnt_valid && s_ready_i;

`ifdef NATV_ARB_TIMEOUT_EN
    logic wd_clr;
    logic wd_en;

    // Held clear outside GRANT, so every grant starts counting from zero.
    assign wd_clr = (state_q != ST_GRANT);
    assign wd_en  = in_gnt && gnt_valid && !s_ready_i;

    natv_arb_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clr_i     (wd_clr),
        .cnt_en_i  (wd_en),
        .expired_o (expired)
    );
`else
    assign expired = 1'b0;
`endif

    assign fin = hit || expired;

    // On a tie, the master not granted last time wins.
    always_comb begin
        pick = m1_valid_i;
        if (m0_valid_i && m1_valid_i) begin
            pick = ~last_q;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        unique case (state_q)
            ST_IDLE: begin
                if (m0_valid_i || m1_valid_i) begin
                    state_d   = ST_GRANT;
                    gnt_d.vld = 1'b1;
                    gnt_d.idx = pick;
                    last_d    = pick;
                end
            end
            ST_GRANT: begin
                if (!gnt_valid) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                end else if (fin) begin
                    state_d = ST_DONE;
                    gnt_d   = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    // Slave side: mux on the registered grant, zero when nobody owns the port.
    always_comb begin
        s_valid_o = in_gnt && gnt_valid;
        s_addr_o  = '0;
        s_wdata_o = '0;
        s_wstrb_o = '0;
        if (in_gnt) begin
            s_addr_o  = gnt_q.idx ? m1_addr_i  : m0_addr_i;
            s_wdata_o = gnt_q.idx ? m1_wdata_i : m0_wdata_i;
            s_wstrb_o = gnt_q.idx ? m1_wstrb_i : m0_wstrb_i;
        end
    end

    // A real answer beats a watchdog expiry in the same cycle.
    assign rsp = s_ready_i ? s_rdata_i : DATA_W'(NATV_ERR_RDATA);

    always_comb begin
        m0_ready_o = fin && !gnt_q.idx;
        m1_ready_o = fin && gnt_q.idx;
        m0_rdata_o = m0_ready_o ? rsp : '0;
        m1_rdata_o = m1_ready_o ? rsp : '0;
        timeout_o  = expired;
    end

endmodule

// File: tb/tb_natv_arb2.sv
// tb_natv_arb2: directed and randomized checks of natv_arb2 against a bench model.
// Build with +define+NATV_ARB_TIMEOUT_EN to cover the watchdog (TIMEOUT_CYC=8).
module tb_natv_arb2;

    localparam int T_CYC = 8;
`ifdef NATV_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        m0_valid_i = 1'b0, m1_valid_i = 1'b0;
    logic [31:0] m0_addr_i = '0, m1_addr_i = '0;
    logic [31:0] m0_wdata_i = '0, m1_wdata_i = '0;
    logic [3:0]  m0_wstrb_i = '0, m1_wstrb_i = '0;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        m0_ready_o, m1_ready_o;
    logic        s_valid_o;
    logic [31:0] s_addr_o, s_wdata_o;
    logic [3:0]  s_wstrb_o;
    logic [31:0] s_rdata_i = '0;
    logic        s_ready_i = 1'b0;
    logic        timeout_o;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    natv_arb2 #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(T_CYC)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i),
        .m0_valid_i(m0_valid_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
        .m0_wstrb_i(m0_wstrb_i), .m0_rdata_o(m0_rdata_o), .m0_ready_o(m0_ready_o),
        .m1_valid_i(m1_valid_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m1_wstrb_i(m1_wstrb_i), .m1_rdata_o(m1_rdata_o), .m1_ready_o(m1_ready_o),
        .s_valid_o(s_valid_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
        .s_wstrb_o(s_wstrb_o), .s_rdata_i(s_rdata_i), .s_ready_i(s_ready_i),
        .timeout_o(timeout_o)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: who owns the slave, whether we are in the cool-down
    // cycle, who won last, and how long the owner has waited.
    int phase = 0;   // 0 free, 1 owned, 2 cool-down
    int owner = 0;
    int last_won = 1;
    int waited = 0;

    always @(negedge clk) begin
        logic        v[2];
        logic [31:0] a[2], wd[2];
        logic [3:0]  ws[2];
        logic        e_rdy[2];
        logic [31:0] e_rd[2];
        logic        e_sv, e_to;
        logic [31:0] e_sa, e_swd;
        logic [3:0]  e_sws;
        v[0] = m0_valid_i; v[1] = m1_valid_i;
        a[0] = m0_addr_i;  a[1] = m1_addr_i;
        wd[0] = m0_wdata_i; wd[1] = m1_wdata_i;
        ws[0] = m0_wstrb_i; ws[1] = m1_wstrb_i;
        e_rdy[0] = 0; e_rdy[1] = 0; e_rd[0] = 0; e_rd[1] = 0;
        e_sv = 0; e_to = 0; e_sa = 0; e_swd = 0; e_sws = 0;
        if (!rst_n_i) begin
            phase = 0; owner = 0; last_won = 1; waited = 0;
        end else if (phase == 1) begin
            e_sv = v[owner];
            e_sa = a[owner]; e_swd = wd[owner]; e_sws = ws[owner];
            if (!v[owner]) begin
                phase = 0;
            end else if (s_ready_i) begin
                e_rdy[owner] = 1; e_rd[owner] = s_rdata_i; phase = 2;
            end else if (TO_EN && waited == T_CYC - 1) begin
                e_rdy[owner] = 1; e_rd[owner] = 32'hDEAD_BEEF;
                e_to = 1; phase = 2;
            end else begin
                waited++;
            end
        end else if (phase == 2) begin
            phase = 0;
        end else if (v[0] || v[1]) begin
            owner = (v[0] && v[1]) ? 1 - last_won : (v[0] ? 0 : 1);
            last_won = owner; waited = 0; phase = 1;
        end
        chk("s_valid", s_valid_o, e_sv);
        chk("s_addr", s_addr_o, e_sa);
        chk("s_wdata", s_wdata_o, e_swd);
        chk("s_wstrb", s_wstrb_o, e_sws);
        chk("m0_ready", m0_ready_o, e_rdy[0]);
        chk("m1_ready", m1_ready_o, e_rdy[1]);
        chk("m0_rdata", m0_rdata_o, e_rd[0]);
        chk("m1_rdata", m1_rdata_o, e_rd[1]);
        chk("timeout", timeout_o, e_to);
    end

    task automatic do_reset();
        rst_n_i = 0;
        step();
        step();
        rst_n_i = 1;
    endtask

    task automatic idle_all();
        m0_valid_i = 0; m1_valid_i = 0; s_ready_i = 0; s_rdata_i = 0;
    endtask

    initial begin
        logic [31:0] got[4];
        logic [31:0] want[4];
        int n;
        logic r0, r1;
        idle_all();
        #2;
        chk("rst_s_valid", s_valid_o, 0);
        chk("rst_m0_ready", m0_ready_o, 0);
        chk("rst_timeout", timeout_o, 0);
        step();
        step();
        rst_n_i = 1;

        // single read from m0
        m0_valid_i = 1; m0_addr_i = 32'h1000; m0_wstrb_i = 0; m0_wdata_i = 0;
        #1 chk("rd_sv_lat0", s_valid_o, 0);
        step();
        #1 chk("rd_sv_lat1", s_valid_o, 1);
        chk("rd_addr", s_addr_o, 32'h1000);
        s_ready_i = 1; s_rdata_i = 32'h1234_5678;
        #1 chk("rd_m0_ready", m0_ready_o, 1);
        chk("rd_m0_rdata", m0_rdata_o, 32'h1234_5678);
        chk("rd_m1_ready", m1_ready_o, 0);
        step();
        idle_all();
        #1 chk("rd_done_sv", s_valid_o, 0);
        chk("rd_done_rdy", m0_ready_o, 0);
        step();

        // tie from reset, slave always ready
        do_reset();
        m0_valid_i = 1; m0_addr_i = 32'hA0; m1_valid_i = 1; m1_addr_i = 32'hB0;
        s_ready_i = 1; s_rdata_i = 32'h77;
        n = 0;
        for (int i = 0; i < 24 && n < 4; i++) begin
            #1;
            if (s_valid_o && s_ready_i) begin
                got[n] = s_addr_o;
                n++;
            end
            step();
        end
        chk("tie_count", n, 4);
        want[0] = 32'hA0; want[1] = 32'hB0; want[2] = 32'hA0; want[3] = 32'hB0;
        for (int i = 0; i < 4; i++) begin
            if (i < n) chk("tie_order", got[i], want[i]);
        end
        idle_all();
        step();
        step();
        step();

        // write forwarding from m1
        m1_valid_i = 1; m1_addr_i = 0; m1_wdata_i = 32'hA5; m1_wstrb_i = 4'h1;
        step();
        #1 chk("wr_wdata", s_wdata_o, 32'hA5);
        chk("wr_wstrb", s_wstrb_o, 4'h1);
        chk("wr_sv", s_valid_o, 1);
        s_ready_i = 1;
        #1 chk("wr_m1_ready", m1_ready_o, 1);
        chk("wr_m0_ready", m0_ready_o, 0);
        step();
        s_ready_i = 0;
        #1 chk("wr_done_sv", s_valid_o, 0);
        idle_all();
        step();
        step();

        // abort then stray ready
        m0_valid_i = 1; m0_addr_i = 32'h40;
        step();
        #1 chk("ab_sv", s_valid_o, 1);
        m0_valid_i = 0;
        #1 chk("ab_sv_drop", s_valid_o, 0);
        chk("ab_rdy", m0_ready_o, 0);
        step();
        s_ready_i = 1; s_rdata_i = 32'h99;
        #1 chk("stray_m0", m0_ready_o, 0);
        chk("stray_m1", m1_ready_o, 0);
        step();
        idle_all();
        step();

        // reset in the middle of a grant
        m1_valid_i = 1; m1_addr_i = 32'h20;
        step();
        #1 chk("rm_sv", s_valid_o, 1);
        rst_n_i = 0;
        #1 chk("rm_sv_async", s_valid_o, 0);
        step();
        rst_n_i = 1;
        m0_valid_i = 1; m0_addr_i = 32'h10;
        step();
        #1 chk("rm_tie_m0", s_addr_o, 32'h10);
        idle_all();
        step();
        step();

        // silent slave: watchdog fires in the 8th GRANT cycle, or waits forever
        m0_valid_i = 1; m0_addr_i = 32'h300;
        step();
        for (int k = 1; k <= 8; k++) begin
            #1 chk("to_rdy", m0_ready_o, TO_EN && k == 8);
            chk("to_pulse", timeout_o, TO_EN && k == 8);
            if (TO_EN && k == 8) chk("to_rdata", m0_rdata_o, 32'hDEAD_BEEF);
            step();
        end
        idle_all();
        step();
        step();
        m0_valid_i = 1;
        step();
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) begin
                s_ready_i = 1; s_rdata_i = 32'h55AA;
            end
            #1 chk("tor_rdy", m0_ready_o, k == 8);
            chk("tor_pulse", timeout_o, 0);
            if (k == 8) chk("tor_rdata", m0_rdata_o, 32'h55AA);
            step();
        end
        idle_all();
        step();
        step();

        // randomized traffic, checked by the model every cycle
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            r0 = m0_ready_o;
            r1 = m1_ready_o;
            @(posedge clk);
            #1;
            if (m0_valid_i) begin
                if (r0) begin
                    m0_valid_i = $urandom_range(1, 0);
                    m0_addr_i = $urandom; m0_wdata_i = $urandom;
                    m0_wstrb_i = 4'($urandom);
                end else if ($urandom_range(63, 0) == 0) begin
                    m0_valid_i = 0;
                end
            end else if ($urandom_range(2, 0) == 0) begin
                m0_valid_i = 1;
                m0_addr_i = $urandom; m0_wdata_i = $urandom;
                m0_wstrb_i = 4'($urandom);
            end
            if (m1_valid_i) begin
                if (r1) begin
                    m1_valid_i = $urandom_range(1, 0);
                    m1_addr_i = $urandom; m1_wdata_i = $urandom;
                    m1_wstrb_i = 4'($urandom);
                end else if ($urandom_range(63, 0) == 0) begin
                    m1_valid_i = 0;
                end
            end else if ($urandom_range(2, 0) == 0) begin
                m1_valid_i = 1;
                m1_addr_i = $urandom; m1_wdata_i = $urandom;
                m1_wstrb_i = 4'($urandom);
            end
            s_ready_i = ($urandom_range(2, 0) == 0);
            s_rdata_i = $urandom;
            if (c == 2500) begin
                rst_n_i = 0;
                step();
                rst_n_i = 1;
            end
        end
        idle_all();
        step();
        step();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
